// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART program loader: 8N1 receive, framed image to 16-bit memory writes, CPU hold.
// Optional macro UART_LOADER_CHECKSUM_EN adds the trailing checksum byte and its comparison.
module uart_loader #(
   parameter int CLKS_PER_BIT = 104,
   parameter int ADDR_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [15:0]           mem_data,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
   typedef enum logic [2:0] {L_WAIT, L_LEN, L_HI, L_LO, L_WR, L_CSUM, L_DONE, L_ERR} l_state_t;

   r_state_t r_state, r_next;
   l_state_t l_state, l_next;

   logic          rx_s1, rx_s2, rx_q;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_valid, frame_err;
   logic          bit_tick, fall;

   logic [8:0]    len_words, word_cnt;
   logic [7:0]    hi_byte;
   logic          last_word;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif

   // rx_q is one extra stage so the falling edge is seen on synchronized data only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_q  <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_q  <= rx_s2;
      end
   end

   assign fall     = rx_q & ~rx_s2;
   assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (fall) r_next = R_START;
         R_START: if (cnt == CW'(HALF - 1)) r_next = rx_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (bit_tick && bit_idx == 3'd7) r_next = R_STOP;
         R_STOP:  if (bit_tick) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= R_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_state <= r_next;
         if (r_state == R_IDLE || r_next != r_state || bit_tick)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (r_state == R_IDLE && fall)
            bit_idx <= '0;
         if (r_state == R_DATA && bit_tick) begin
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
         byte_valid <= (r_state == R_STOP) && bit_tick && rx_s2;
         frame_err  <= (r_state == R_STOP) && bit_tick && !rx_s2;
      end
   end

   assign last_word = (word_cnt + 9'd1 == len_words);
   assign mem_we    = (l_state == L_WR);

   always_comb begin
      l_next = l_state;
      if (frame_err && (l_state inside {L_LEN, L_HI, L_LO, L_WR, L_CSUM})) begin
         l_next = L_ERR;
      end else begin
         case (l_state)
            L_WAIT, L_DONE, L_ERR: if (byte_valid && shreg == 8'hA5) l_next = L_LEN;
            L_LEN: if (byte_valid) l_next = L_HI;
            L_HI:  if (byte_valid) l_next = L_LO;
            L_LO:  if (byte_valid) l_next = L_WR;
`ifdef UART_LOADER_CHECKSUM_EN
            L_WR:  l_next = last_word ? L_CSUM : L_HI;
            L_CSUM: if (byte_valid) l_next = (shreg == csum) ? L_DONE : L_ERR;
`else
            L_WR:  l_next = last_word ? L_DONE : L_HI;
`endif
            default: l_next = L_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_state   <= L_WAIT;
         mem_addr  <= '0;
         mem_data  <= '0;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         len_words <= '0;
         word_cnt  <= '0;
         hi_byte   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         l_state <= l_next;
         case (l_state)
            L_WAIT, L_DONE, L_ERR: begin
               if (l_next == L_LEN) begin
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
               end
            end
            L_LEN: begin
               if (byte_valid) begin
                  // a length byte of zero encodes a full 256-word image
                  len_words <= (shreg == 8'd0) ? 9'd256 : {1'b0, shreg};
                  mem_addr  <= '0;
                  word_cnt  <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                  csum      <= '0;
`endif
               end
            end
            L_HI: begin
               if (byte_valid) begin
                  hi_byte <= shreg;
`ifdef UART_LOADER_CHECKSUM_EN
                  csum    <= csum + shreg;
`endif
               end
            end
            L_LO: begin
               if (byte_valid) begin
                  mem_data <= {hi_byte, shreg};
`ifdef UART_LOADER_CHECKSUM_EN
                  csum     <= csum + shreg;
`endif
               end
            end
            L_WR: begin
               mem_addr <= mem_addr + 1'b1;
               word_cnt <= word_cnt + 9'd1;
            end
            default: ;
         endcase
         if (l_next == L_ERR && l_state != L_ERR) begin
            error    <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
         end
         if (l_next == L_DONE && l_state != L_DONE) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - scoreboard bench for uart_loader with a frame-level image model.
module tb_uart_loader;

   localparam int CPB = 8;
`ifdef UART_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data;
   logic        cpu_hold, done, error;

   int checks = 0;
   int errors = 0;
   int writes_seen = 0;
   int writes_exp  = 0;

   logic [7:0]  exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   logic [15:0] wq[$];
   logic [7:0]  m_a;
   logic [15:0] m_d;

   uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .rx(rx),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every write strobe must match the next expected word
   always @(negedge clk) begin
      if (rst === 1'b0 && mem_we === 1'b1) begin
         writes_seen++;
         if (exp_data_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0h data %0h with nothing expected", mem_addr, mem_data);
         end else begin
            m_a = exp_addr_q.pop_front();
            m_d = exp_data_q.pop_front();
            check("wr_addr", {24'd0, mem_addr}, {24'd0, m_a});
            check("wr_data", {16'd0, mem_data}, {16'd0, m_d});
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop;
      idle(CPB);
      rx = 1'b1;
      idle(4);
   endtask

   task automatic glitch();
      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(40);
   endtask

   // Builds an image of n words (from wq, else random), predicts its writes and final flags.
   task automatic send_image(input int n, input bit bad, input int err_at, input bit do_glitch);
      logic [7:0]  bq[$];
      logic [7:0]  sum;
      logic [15:0] w;
      bit          exp_err;
      sum = 8'd0;
      bq.push_back(8'hA5);
      bq.push_back(n[7:0]);
      for (int i = 0; i < n; i++) begin
         w = (i < wq.size()) ? wq[i] : 16'($urandom);
         bq.push_back(w[15:8]);
         bq.push_back(w[7:0]);
         sum = sum + w[15:8] + w[7:0];
         if (err_at < 0 || 3 + 2 * i < err_at) begin
            exp_addr_q.push_back(i[7:0]);
            exp_data_q.push_back(w);
            writes_exp++;
         end
      end
      if (CSUM_EN) bq.push_back(sum + {7'd0, bad});
      for (int k = 0; k < bq.size(); k++) begin
         if (k == err_at) begin
            send_byte(bq[k], 1'b0);
            break;
         end
         send_byte(bq[k], 1'b1);
         if (k == 0) begin
            check("hold_after_hdr", {31'd0, cpu_hold}, 32'd1);
            check("done_after_hdr", {31'd0, done}, 32'd0);
         end
         if (k == 1 && do_glitch) glitch();
      end
      idle(20);
      exp_err = (err_at >= 0) || (CSUM_EN && bad);
      check("img_done",  {31'd0, done},     {31'd0, !exp_err});
      check("img_error", {31'd0, error},    {31'd0, exp_err});
      check("img_hold",  {31'd0, cpu_hold}, {31'd0, exp_err});
      wq.delete();
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(100);
      check("rst_hold",   {31'd0, cpu_hold}, 32'd1);
      check("rst_done",   {31'd0, done},     32'd0);
      check("rst_error",  {31'd0, error},    32'd0);
      check("rst_addr",   {24'd0, mem_addr}, 32'd0);
      check("rst_no_wr",  writes_seen,       32'd0);

      wq = {16'h1234, 16'hABCD};
      send_image(2, 1'b0, -1, 1'b0);
      wq = {16'h1234, 16'hABCD};
      send_image(2, 1'b1, -1, 1'b0);
      wq = {16'h1234, 16'hABCD};
      send_image(2, 1'b0, -1, 1'b0);

      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      wq = {16'h0007};
      send_image(1, 1'b0, -1, 1'b0);

      send_image(3, 1'b0, 2, 1'b0);
      send_image(3, 1'b0, 5, 1'b0);

      glitch();
      check("glitch_idle_err", {31'd0, error}, 32'd1);
      send_image(3, 1'b0, -1, 1'b1);
      glitch();
      check("glitch_done_err", {31'd0, error}, 32'd0);
      check("glitch_done",     {31'd0, done},  32'd1);

      for (int r = 0; r < 6; r++)
         send_image($urandom_range(1, 6), 1'($urandom_range(0, 1)), -1, 1'b0);

      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h11, 1'b1);
      rst = 1'b1;
      idle(2);
      check("midrst_hold",  {31'd0, cpu_hold}, 32'd1);
      check("midrst_done",  {31'd0, done},     32'd0);
      check("midrst_error", {31'd0, error},    32'd0);
      check("midrst_addr",  {24'd0, mem_addr}, 32'd0);
      rst = 1'b0;
      idle(10);
      send_image(2, 1'b0, -1, 1'b0);

      send_image(256, 1'b0, -1, 1'b0);

      idle(20);
      check("writes_total", writes_seen, writes_exp);
      check("queue_empty", exp_data_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
